// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte/word helpers.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  localparam int BLK_W = 128;
  localparam int NB    = 4;

  typedef logic [0:BLK_W-1] block_t;
  typedef logic [0:31]      word_t;

  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic word_t sub_word(input word_t w);
    word_t r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox(w[8*i +: 8]);
    return r;
  endfunction

  // Next round key: w3 rotated, substituted and rcon-mixed, then chained.
  function automatic block_t key_step(input block_t rk,
                                      input logic [7:0] rcon);
    word_t  w [NB];
    word_t  t;
    block_t n;
    for (int i = 0; i < NB; i++) w[i] = rk[32*i +: 32];
    t = sub_word({w[3][8:31], w[3][0:7]}) ^ {rcon, 24'h000000};
    n[0:31] = w[0] ^ t;
    for (int i = 1; i < NB; i++)
      n[32*i +: 32] = w[i] ^ n[32*(i-1) +: 32];
    return n;
  endfunction

endpackage

// File: rtl/aes_round.sv
// Combinational AES encryption round; MixColumns skipped on the last round.
module aes_round
  import aes_pkg::*;
(
  input  block_t st,
  input  block_t rk,
  input  logic   last,
  output block_t out
);

  function automatic word_t mix_col(input word_t a);
    logic [7:0] a0, a1, a2, a3;
    a0 = a[0:7];
    a1 = a[8:15];
    a2 = a[16:23];
    a3 = a[24:31];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  block_t sb;
  block_t sr;
  block_t mc;

  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int i = 0; i < 16; i++)
      sb[8*i +: 8] = sbox(st[8*i +: 8]);
    // Row r shifts left by r columns; byte index is r + 4*c.
    for (int c = 0; c < NB; c++)
      for (int r = 0; r < 4; r++)
        sr[8*(r+4*c) +: 8] = sb[8*(r+4*((c+r)%4)) +: 8];
    for (int c = 0; c < NB; c++)
      mc[32*c +: 32] = mix_col(sr[32*c +: 32]);
    out = (last ? sr : mc) ^ rk;
  end

endmodule

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryptor: one shared round per clock, keys on the fly.
module aes128_iter_ctrl
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  input  logic [0:127] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         busy,
  output logic [3:0]   round
);

  if (Nk != 4 || Nr != 10) begin : g_param_err
    $fatal(1, "aes128_iter_ctrl: only Nk=4, Nr=10 supported");
  end

  state_e     state;
  state_e     state_n;
  block_t     st;
  block_t     rk;
  block_t     rk_n;
  block_t     rnd_out;
  logic [7:0] rcon;
  logic       last;
  logic       accept;

  assign last     = (round == 4'(Nr));
  assign rk_n     = key_step(rk, rcon);
  assign out_data = st;

  aes_round u_round (
    .st   (st),
    .rk   (rk_n),
    .last (last),
    .out  (rnd_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept  = 1'b1;
          state_n = ROUND;
        end
      end
      ROUND: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= '0;
      rk    <= '0;
      rcon  <= '0;
      round <= '0;
    end else if (accept) begin
      st    <= in_data ^ in_key;
      rk    <= in_key;
      rcon  <= 8'h01;
      round <= 4'd1;
    end else if (state == ROUND) begin
      st   <= rnd_out;
      rk   <= rk_n;
      rcon <= xtime(rcon);
      if (!last) round <= round + 4'd1;
    end else if (state == DONE && out_ready) begin
      round <= '0;
    end
  end

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Directed bench for aes128_iter_ctrl using FIPS-197 vectors.
module tb_aes128_iter_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] in_data;
  logic [0:127] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_data;
  logic         busy;
  logic [3:0]   round;

  int errors = 0;
  int checks = 0;

  localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] C1_X0  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [0:127] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  aes128_iter_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .round     (round)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [0:127] d, input logic [0:127] k);
    in_valid = 1'b1;
    in_data  = d;
    in_key   = k;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    check({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    check({tag, "_out_data"}, 128'(out_data), 128'd0);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_round"}, 128'(round), 128'd0);
  endtask

  task automatic wait_done(input string tag, input logic [0:127] exp);
    int n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_done_seen"}, 128'(out_valid), 128'd1);
    check({tag, "_ct"}, 128'(out_data), 128'(exp));
  endtask

  initial begin
    logic [0:127] held;
    logic [0:127] ct1, ct2;
    int t1, t2, cyc;
    logic acc;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_key    = '0;
    out_ready = 1'b0;
    step();
    check_reset_outs("reset");
    step();
    rst = 1'b0;
    step();
    check_reset_outs("post_reset");

    // C.1: exact latency and round stepping
    accept(C1_PT, C1_KEY);
    check("c1_r1", 128'(round), 128'd1);
    check("c1_busy", 128'(busy), 128'd1);
    check("c1_in_ready", 128'(in_ready), 128'd0);
    check("c1_addkey", 128'(out_data), 128'(C1_X0));
    in_data = '1;
    in_key  = '1;
    for (int k = 2; k <= 10; k++) begin
      step();
      check($sformatf("c1_round%0d", k), 128'(round), 128'(k));
      check($sformatf("c1_nvalid%0d", k), 128'(out_valid), 128'd0);
    end
    step();
    check("c1_valid_t10", 128'(out_valid), 128'd1);
    check("c1_round_done", 128'(round), 128'd10);
    check("c1_ct", 128'(out_data), 128'(C1_CT));

    // backpressure
    held = out_data;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_stable", 128'(out_data), 128'(held));
      check("bp_valid", 128'(out_valid), 128'd1);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      check("bp_busy", 128'(busy), 128'd1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_rel_idle", 128'(in_ready), 128'd1);
    check("bp_rel_busy", 128'(busy), 128'd0);
    check("bp_rel_valid", 128'(out_valid), 128'd0);
    check("bp_rel_round", 128'(round), 128'd0);

    // App. B with an ignored in_valid pulse at round 4
    accept(B_PT, B_KEY);
    repeat (3) step();
    check("busy_in_r4", 128'(round), 128'd4);
    in_valid = 1'b1;
    in_data  = C1_PT;
    in_key   = C1_KEY;
    step();
    in_valid = 1'b0;
    check("busy_in_r5", 128'(round), 128'd5);
    wait_done("appb", B_CT);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("appb_idle", 128'(in_ready), 128'd1);

    // reset in the middle of a block
    accept(C1_PT, C1_KEY);
    repeat (4) step();
    check("rst_mid_r5", 128'(round), 128'd5);
    rst = 1'b1;
    #1;
    check_reset_outs("rst_mid");
    step();
    rst = 1'b0;
    step();
    accept(C1_PT, C1_KEY);
    out_ready = 1'b1;
    wait_done("rst_next", C1_CT);
    step();
    out_ready = 1'b0;

    // back-to-back with in_valid held high
    in_valid  = 1'b1;
    in_data   = C1_PT;
    in_key    = C1_KEY;
    out_ready = 1'b1;
    t1 = -1;
    t2 = -1;
    ct1 = '0;
    ct2 = '0;
    cyc = 0;
    while (cyc < 40 && (t2 < 0 || ct2 == '0)) begin
      acc = in_ready & in_valid;
      step();
      cyc++;
      if (acc && t1 < 0) begin
        t1 = cyc;
        in_data = B_PT;
        in_key  = B_KEY;
      end else if (acc && t2 < 0) begin
        t2 = cyc;
        in_valid = 1'b0;
      end
      if (out_valid && ct1 == '0) ct1 = out_data;
      else if (out_valid) ct2 = out_data;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_gap", 128'(t2 - t1), 128'd12);
    check("b2b_ct1", 128'(ct1), 128'(C1_CT));
    check("b2b_ct2", 128'(ct2), 128'(B_CT));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
